// File: rtl/maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_2x2_stream
//  Description : Streaming 2x2 / stride-2 signed max-pool over one raster
//                feature map, one pixel per cycle, valid/ready on both sides.
//                A half-row line buffer holds the horizontal pair maxima of
//                each even row, so no frame storage is needed.
//                Optional macro MAXPOOL_FUSED_RELU_EN clamps negative inputs
//                to zero before any comparison (fused ReLU).
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 45,
  parameter int IN_X       = 24,
  parameter int IN_Y       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int c_out_x = IN_X / 2;
  localparam int c_out_y = IN_Y / 2;
  localparam int c_total = c_out_x * c_out_y;
  localparam int c_col_w = $clog2(IN_X);
  localparam int c_row_w = $clog2(IN_Y);
  localparam int c_cnt_w = (c_total > 1) ? $clog2(c_total) : 1;
  localparam int c_lb_w  = (c_out_x > 1) ? $clog2(c_out_x) : 1;

  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IN_X - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IN_Y - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_total - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                  state_q;
  logic [c_col_w-1:0]      col_q;
  logic [c_row_w-1:0]      row_q;
  logic [c_cnt_w-1:0]      out_cnt_q;
  logic [DATA_WIDTH-1:0]   h_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   linebuf_q [c_out_x];

  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_pix;
  logic [DATA_WIDTH-1:0]   w_pair;
  logic [DATA_WIDTH-1:0]   w_win;
  logic [c_lb_w-1:0]       w_lb_idx;
  logic                    w_col_end;
  logic                    w_row_end;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

`ifdef MAXPOOL_FUSED_RELU_EN
  // Negative pixels are clamped to zero before they enter the comparators.
  assign w_pix = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign w_pix = in_data;
`endif

  // Stall only while the output register is full and not draining.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_lb_idx  = c_lb_w'(col_q >> 1);
  assign w_pair    = smax(h_q, w_pix);
  assign w_win     = smax(linebuf_q[w_lb_idx], w_pair);
  assign w_col_end = (col_q == c_col_last);
  assign w_row_end = (row_q == c_row_last);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  // Even-row pair maxima wait here for the matching odd row; no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept && col_q[0] && !row_q[0]) begin
      linebuf_q[w_lb_idx] <= w_pair;
    end
  end

  // Frame control, raster counters, hold register and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_cnt_q   <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Drain on handshake; a result loaded below in the same cycle overrides.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_col_end) begin
              col_q <= '0;
              if (w_row_end) begin
                row_q   <= '0;
                state_q <= S_FLUSH;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (!col_q[0]) begin
              h_q <= w_pix;
            end else if (row_q[0]) begin
              out_data_q  <= w_win;
              out_valid_q <= 1'b1;
              out_last_q  <= (out_cnt_q == c_cnt_last);
              out_cnt_q   <= out_cnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (out_valid_q && out_ready && out_last_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_2x2_stream
//  Description : Scoreboard bench for maxpool_2x2_stream. Expected pooled
//                pixels are queued when a frame is issued; a monitor pops
//                and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2_stream;

  localparam int DW   = 45;
  localparam int IX   = 24;
  localparam int IY   = 24;
  localparam int NPIX = IX * IY;
  localparam int OX   = IX / 2;
  localparam int OY   = IY / 2;
  localparam int NOUT = OX * OY;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] pix [NPIX];
  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            done_cnt = 0;
  int            or_mode  = 0;

  maxpool_2x2_stream #(.DATA_WIDTH(DW), .IN_X(IX), .IN_Y(IY)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef MAXPOOL_FUSED_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // out_ready: 0 = always ready, 1 = random, 2 = held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every output handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, none expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_last", 64'(out_last), 64'(e.l));
        end
      end
    end
  end

  task automatic fill_ramp();
    for (int k = 0; k < NPIX; k++) pix[k] = DW'(k);
  endtask

  // Hand formula for the ramp: window (r,c) max is its bottom-right pixel.
  task automatic push_ramp(input int limit, input int skip);
    exp_t e;
    for (int r = 0; r < OY; r++)
      for (int c = 0; c < OX; c++) begin
        if ((r * OX + c) >= skip && ((2 * r + 1) * IX + 2 * c + 1) < limit) begin
          e.d = DW'((2 * r + 1) * IX + 2 * c + 1);
          e.l = ((r * OX + c) == NOUT - 1);
          exp_q.push_back(e);
        end
      end
  endtask

  task automatic push_model();
    exp_t e;
    int   tl;
    for (int r = 0; r < OY; r++)
      for (int c = 0; c < OX; c++) begin
        tl  = 2 * r * IX + 2 * c;
        e.d = smax(smax(relu(pix[tl]), relu(pix[tl + 1])),
                   smax(relu(pix[tl + IX]), relu(pix[tl + IX + 1])));
        e.l = ((r * OX + c) == NOUT - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_pixels(input int limit, input bit rnd, output int first_c, output int last_c);
    int k = 0;
    int stall = 0;
    first_c = 0;
    last_c  = 0;
    while (k < limit) begin
      in_data  = pix[k];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (k == 0) first_c = cyc;
        if (k == limit - 1) last_c = cyc;
        k++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 500) begin
          checks++;
          errors++;
          $display("FAIL input_timeout: pixel %0d not accepted, required acceptance", k);
          k = limit;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d0);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("frame_end_timeout", 64'(n < 4000), 64'(1));
    chk("done_count", 64'(done_cnt - d0), 64'(1));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   f, l, d0;
    exp_t e;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    or_mode  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp frame, full throughput
    fill_ramp();
    push_ramp(NPIX, 0);
    d0 = done_cnt;
    pulse_start();
    run_pixels(NPIX, 1'b0, f, l);
    chk("throughput_cycles", 64'(l - f), 64'(NPIX - 1));
    wait_idle(d0);

    // Signed-comparison windows at the top-left of a ramp frame
    fill_ramp();
    pix[0]      = -45'sd5;
    pix[1]      = -45'sd3;
    pix[IX]     = -45'sd8;
    pix[IX + 1] = -45'sd1;
    pix[2]      = {1'b1, 44'd0};
    pix[3]      = 45'd7;
    pix[IX + 2] = 45'd0;
    pix[IX + 3] = 45'd6;
`ifdef MAXPOOL_FUSED_RELU_EN
    e.d = '0;
`else
    e.d = -45'sd1;
`endif
    e.l = 1'b0;
    exp_q.push_back(e);
    e.d = 45'd7;
    exp_q.push_back(e);
    push_ramp(NPIX, 2);
    d0 = done_cnt;
    pulse_start();
    run_pixels(NPIX, 1'b0, f, l);
    wait_idle(d0);

    // Backpressure after the first output
    fill_ramp();
    push_ramp(NPIX, 0);
    or_mode = 2;
    d0 = done_cnt;
    pulse_start();
    fork
      run_pixels(NPIX, 1'b0, f, l);
      begin
        int n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_output_seen", 64'(out_valid), 64'(1));
        repeat (10) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(in_ready), 64'(0));
          chk("bp_out_data_hold", 64'(out_data), 64'(25));
          chk("bp_out_valid_hold", 64'(out_valid), 64'(1));
        end
        or_mode = 0;
      end
    join
    wait_idle(d0);

    // Two random frames with random handshakes and ignored start pulses
    or_mode = 1;
    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < NPIX; k++) pix[k] = DW'({$urandom(), $urandom()});
      push_model();
      d0 = done_cnt;
      pulse_start();
      fork
        run_pixels(NPIX, 1'b1, f, l);
        begin
          repeat (3) begin
            repeat ($urandom_range(50, 150)) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
          end
        end
      join
      wait_idle(d0);
    end

    // Reset at input pixel 300, then a fresh ramp frame
    or_mode = 0;
    fill_ramp();
    push_ramp(300, 0);
    d0 = done_cnt;
    pulse_start();
    run_pixels(300, 1'b0, f, l);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_out_data", 64'(out_data), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    chk("abort_out_last", 64'(out_last), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    chk("abort_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    push_ramp(NPIX, 0);
    d0 = done_cnt;
    pulse_start();
    run_pixels(NPIX, 1'b0, f, l);
    wait_idle(d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
